// File: rtl/if_id_pkg.sv
// Shared IF/ID stall-buffer definitions: controller state encoding and default depth.
package if_id_pkg;

  localparam int DEFAULT_DEPTH = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2,
    FLUSH = 2'd3
  } state_t;

endpackage

// File: rtl/buf_occ_counter.sv
// Stall-buffer occupancy counter; clear wins, a simultaneous inc and dec holds the value.
module buf_occ_counter #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             inc,
  input  logic             dec,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (clr)
      count <= '0;
    else if (inc && !dec)
      count <= count + CNT_W'(1);
    else if (dec && !inc)
      count <= count - CNT_W'(1);
  end

endmodule

// File: rtl/if_buffer_ctrl.sv
// IF/ID stall-buffer controller: captures fetched instructions while decode stalls,
// replays them in order afterwards, and discards them on a redirect.
module if_buffer_ctrl
  import if_id_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             inst_valid,
  input  logic             redirect,
  output logic             buffer_write_en,
  output logic             buffer_read_en,
  output logic             buffer_reset,
  output logic             if_buffer_stall,
  output logic             buffer_active,
  output logic             buffer_sel,
  output logic [CNT_W-1:0] count,
  output logic [1:0]       state
);

  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] count_next;
  logic             full;
  logic             count_clr;

  always_ff @(posedge clk) begin
    if (reset)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  // Outputs are masked during reset so no push or pop escapes the reset cycle.
  always_comb begin
    full            = (count == FULL_COUNT);
    buffer_write_en = 1'b0;
    buffer_read_en  = 1'b0;
    buffer_reset    = 1'b1;
    if_buffer_stall = 1'b0;
    buffer_active   = 1'b0;
    if (!reset) begin
      buffer_write_en = inst_valid && !redirect && !full &&
                        ((stall && (state_q == IDLE || state_q == FILL)) || state_q == DRAIN);
      buffer_read_en  = (state_q == DRAIN) && !stall && (count != '0) && !redirect;
      buffer_reset    = (state_q == FLUSH);
      if_buffer_stall = full || (state_q == FLUSH);
      buffer_active   = (state_q == DRAIN);
    end
    buffer_sel = buffer_active;
  end

  always_comb begin
    count_next = count;
    if (buffer_write_en && !buffer_read_en)
      count_next = count + CNT_W'(1);
    else if (buffer_read_en && !buffer_write_en)
      count_next = count - CNT_W'(1);
  end

  // FILL and DRAIN share exits: stall parks in FILL, otherwise drain until empty.
  always_comb begin
    state_d = state_q;
    if (redirect) begin
      state_d = FLUSH;
    end else begin
      case (state_q)
        IDLE:        if (stall) state_d = FILL;
        FILL, DRAIN: begin
          if (stall)
            state_d = FILL;
          else if (count_next == '0)
            state_d = IDLE;
          else
            state_d = DRAIN;
        end
        FLUSH:       state_d = IDLE;
      endcase
    end
  end

  // Occupancy drops to zero as soon as a redirect is seen, so FLUSH already reads empty.
  assign count_clr = reset || redirect || (state_q == FLUSH);

  buf_occ_counter #(
    .CNT_W(CNT_W)
  ) u_occ (
    .clk   (clk),
    .inc   (buffer_write_en),
    .dec   (buffer_read_en),
    .clr   (count_clr),
    .count (count)
  );

  assign state = state_q;

endmodule

// File: tb/tb_if_buffer_ctrl.sv
// Randomised bench for if_buffer_ctrl: a queue-based occupancy model predicts every output each cycle.
module tb_if_buffer_ctrl;
  import if_id_pkg::*;

  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             clk;
  logic             reset;
  logic             stall;
  logic             inst_valid;
  logic             redirect;
  logic             buffer_write_en;
  logic             buffer_read_en;
  logic             buffer_reset;
  logic             if_buffer_stall;
  logic             buffer_active;
  logic             buffer_sel;
  logic [CNT_W-1:0] count;
  logic [1:0]       state;

  int checks = 0;
  int passes = 0;

  state_t m_mode = IDLE;
  int     m_q[$];
  int     m_tag = 0;
  bit     m_we;
  bit     m_re;

  if_buffer_ctrl #(
    .DEPTH(DEPTH)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .stall           (stall),
    .inst_valid      (inst_valid),
    .redirect        (redirect),
    .buffer_write_en (buffer_write_en),
    .buffer_read_en  (buffer_read_en),
    .buffer_reset    (buffer_reset),
    .if_buffer_stall (if_buffer_stall),
    .buffer_active   (buffer_active),
    .buffer_sel      (buffer_sel),
    .count           (count),
    .state           (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual == expected)
      passes++;
    else
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
  endtask

  // Predicts this cycle's outputs from model mode, queue size and the live inputs.
  task automatic compareModel();
    bit full, flush, br, st, act;
    full  = (m_q.size() == DEPTH);
    flush = (m_mode == FLUSH);
    if (reset) begin
      m_we = 0; m_re = 0; br = 1; st = 0; act = 0;
    end else begin
      m_we = inst_valid && !redirect && !full && (m_mode == DRAIN || (stall && !flush));
      m_re = (m_mode == DRAIN) && !stall && (m_q.size() > 0) && !redirect;
      br   = flush;
      st   = full || flush;
      act  = (m_mode == DRAIN);
    end
    checkOutput("write_en", int'(buffer_write_en), int'(m_we));
    checkOutput("read_en", int'(buffer_read_en), int'(m_re));
    checkOutput("buffer_reset", int'(buffer_reset), int'(br));
    checkOutput("if_buffer_stall", int'(if_buffer_stall), int'(st));
    checkOutput("buffer_active", int'(buffer_active), int'(act));
    checkOutput("buffer_sel", int'(buffer_sel), int'(act));
    checkOutput("count", int'(count), m_q.size());
    checkOutput("state", int'(state), int'(m_mode));
  endtask

  task automatic updateModel();
    if (reset) begin
      m_mode = IDLE;
      m_q.delete();
    end else if (redirect) begin
      m_mode = FLUSH;
      m_q.delete();
    end else if (m_mode == FLUSH) begin
      m_mode = IDLE;
      m_q.delete();
    end else begin
      if (m_re) void'(m_q.pop_front());
      if (m_we) begin
        m_q.push_back(m_tag);
        m_tag++;
      end
      if (m_mode == IDLE)
        m_mode = stall ? FILL : IDLE;
      else
        m_mode = stall ? FILL : ((m_q.size() > 0) ? DRAIN : IDLE);
    end
  endtask

  task automatic applyStimulus(input bit r, input bit s, input bit iv, input bit rd);
    reset      = r;
    stall      = s;
    inst_valid = iv;
    redirect   = rd;
    @(negedge clk);
    compareModel();
    @(posedge clk);
    updateModel();
    #1;
  endtask

  task automatic driveOnly(input bit r, input bit s, input bit iv, input bit rd);
    reset      = r;
    stall      = s;
    inst_valid = iv;
    redirect   = rd;
    #1;
  endtask

  initial begin
    int stall_left;
    bit stall_val;
    reset = 1'b1; stall = 1'b0; inst_valid = 1'b0; redirect = 1'b0;
    @(posedge clk);
    #1;

    applyStimulus(1, 0, 0, 0);
    checkOutput("lit_reset_count", int'(count), 0);
    checkOutput("lit_reset_state", int'(state), int'(IDLE));

    // Three-cycle stall, release, then drain with new fetches continuing.
    repeat (3) applyStimulus(0, 1, 1, 0);
    checkOutput("lit_fill3_count", int'(count), 3);
    checkOutput("lit_fill3_state", int'(state), int'(FILL));
    applyStimulus(0, 0, 1, 0);
    checkOutput("lit_drain_entry_state", int'(state), int'(DRAIN));
    checkOutput("lit_drain_entry_count", int'(count), 3);
    driveOnly(0, 0, 1, 0);
    checkOutput("lit_drain_rw_read", int'(buffer_read_en), 1);
    checkOutput("lit_drain_rw_write", int'(buffer_write_en), 1);
    applyStimulus(0, 0, 1, 0);
    checkOutput("lit_drain_rw_count", int'(count), 3);
    repeat (3) applyStimulus(0, 0, 0, 0);
    checkOutput("lit_drained_count", int'(count), 0);
    checkOutput("lit_drained_state", int'(state), int'(IDLE));

    // Saturation at full depth.
    repeat (5) applyStimulus(0, 1, 1, 0);
    checkOutput("lit_full_count", int'(count), 4);
    driveOnly(0, 1, 1, 0);
    checkOutput("lit_full_write", int'(buffer_write_en), 0);
    checkOutput("lit_full_stall", int'(if_buffer_stall), 1);
    applyStimulus(0, 1, 1, 0);
    checkOutput("lit_full_hold_count", int'(count), 4);
    repeat (5) applyStimulus(0, 0, 0, 0);
    checkOutput("lit_full_drained_state", int'(state), int'(IDLE));

    // Redirect during DRAIN with two entries.
    repeat (2) applyStimulus(0, 1, 1, 0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("lit_pre_redirect_count", int'(count), 2);
    applyStimulus(0, 0, 0, 1);
    driveOnly(0, 0, 0, 0);
    checkOutput("lit_flush_state", int'(state), int'(FLUSH));
    checkOutput("lit_flush_count", int'(count), 0);
    checkOutput("lit_flush_breset", int'(buffer_reset), 1);
    applyStimulus(0, 0, 0, 0);
    checkOutput("lit_post_flush_state", int'(state), int'(IDLE));
    checkOutput("lit_post_flush_sel", int'(buffer_sel), 0);

    // DRAIN with one entry: simultaneous push and pop, then stall re-entry.
    applyStimulus(0, 1, 1, 0);
    applyStimulus(0, 0, 0, 0);
    driveOnly(0, 0, 1, 0);
    checkOutput("lit_d1_read", int'(buffer_read_en), 1);
    checkOutput("lit_d1_write", int'(buffer_write_en), 1);
    applyStimulus(0, 0, 1, 0);
    checkOutput("lit_d1_count", int'(count), 1);
    checkOutput("lit_d1_state", int'(state), int'(DRAIN));
    driveOnly(0, 1, 1, 0);
    checkOutput("lit_restall_read", int'(buffer_read_en), 0);
    applyStimulus(0, 1, 1, 0);
    checkOutput("lit_restall_state", int'(state), int'(FILL));
    checkOutput("lit_restall_count", int'(count), 2);

    // Reset in FILL with three entries.
    applyStimulus(0, 1, 1, 0);
    checkOutput("lit_prerst_count", int'(count), 3);
    driveOnly(1, 1, 1, 0);
    checkOutput("lit_rst_read", int'(buffer_read_en), 0);
    checkOutput("lit_rst_write", int'(buffer_write_en), 0);
    applyStimulus(1, 1, 1, 0);
    checkOutput("lit_rst_state", int'(state), int'(IDLE));
    checkOutput("lit_rst_count", int'(count), 0);

    // Random traffic with bursty stalls, occasional redirects and resets.
    stall_left = 0;
    stall_val  = 0;
    repeat (3000) begin
      if (stall_left == 0) begin
        stall_val  = ($urandom_range(0, 1) == 1);
        stall_left = $urandom_range(1, 8);
      end
      stall_left--;
      applyStimulus($urandom_range(0, 99) == 0, stall_val,
                    $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/if_buffer_ctrl.md
IF_BUFFER_CTRL -- requirements
Module: if_buffer_ctrl

Interface
REQ-001 Parameter DEPTH, default 4, sets stall-buffer entry count; legal values are powers of two, 2..16.
REQ-002 Parameter CNT_W, default $clog2(DEPTH+1), sets occupancy count width.
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 stall  in  1  decode stall request; ID cannot accept an instruction this cycle.
REQ-006 inst_valid  in  1  fetch presents a valid instruction this cycle.
REQ-007 redirect  in  1  PC override from decode (mispredict or jalr fix); buffered instructions are stale.
REQ-008 buffer_write_en  out  1  push the fetched instruction and PC into the stall buffer.
REQ-009 buffer_read_en  out  1  pop the buffer head to ID.
REQ-010 buffer_reset  out  1  clear the buffer pointers.
REQ-011 if_buffer_stall  out  1  hold the fetch PC register.
REQ-012 buffer_active  out  1  the buffer is the instruction source for ID; ID treats the output as valid.
REQ-013 buffer_sel  out  1  ID mux select: 0 = direct fetch, 1 = buffer head.
REQ-014 count  out  CNT_W  current buffer occupancy.
REQ-015 state  out  2  current FSM state, for debug.

Function
REQ-016 FSM states: IDLE, FILL, DRAIN, FLUSH; encoding is defined in the shared package.
REQ-017 redirect in any state SHALL move the FSM to FLUSH next cycle; redirect has priority over all other transitions.
REQ-018 IDLE: buffer_sel=0; stall moves the FSM to FILL, otherwise it stays in IDLE.
REQ-019 buffer_write_en = inst_valid & (state is IDLE or FILL, with stall=1, or state is DRAIN) & (count < DEPTH) & ~redirect & (state != FLUSH).
REQ-020 FILL: if stall=1, stay in FILL; if stall=0 and next count > 0, go to DRAIN; if stall=0 and next count = 0, go to IDLE.
REQ-021 DRAIN: buffer_read_en = ~stall & (count > 0) & ~redirect; buffer_sel=1; buffer_active=1.
REQ-022 DRAIN: stall=1 returns the FSM to FILL with no read; a read that brings next count to 0 returns the FSM to IDLE.
REQ-023 FLUSH: buffer_reset=1, count loads 0, write_en=0, read_en=0, if_buffer_stall=1; the FSM goes to IDLE after one cycle.
REQ-024 count_next = count + write_en - read_en; a simultaneous read and write leaves count unchanged.
REQ-025 count SHALL never exceed DEPTH or underflow below 0; gating in REQ-019 and REQ-021 guarantees this, and no wrap is permitted.
REQ-026 if_buffer_stall = (count == DEPTH) | (state == FLUSH), combinational from registered state; no fetched instruction is lost while full.
REQ-027 buffer_active = 1 in DRAIN only; buffer_sel equals buffer_active.
REQ-028 A write and a read in the same DRAIN cycle SHALL preserve program order: the pop returns the oldest entry.
REQ-029 Latency: the first buffered instruction reaches ID in the cycle after stall deasserts, through the DRAIN transition.

Reset
REQ-030 reset SHALL be sampled synchronously and take priority over redirect.
REQ-031 On reset: state=IDLE, count=0, and all 1-bit outputs are 0 except buffer_reset, which is 1 during the reset cycle.
REQ-032 Reset asserted mid-DRAIN or mid-FILL discards occupancy without emitting a read_en.

Structure
REQ-033 The state enum typedef and the DEPTH default belong in the shared package if_id_pkg.
REQ-034 The occupancy counter is a sub-module, buf_occ_counter (inc, dec, clr, count); everything else is inline FSM logic.
REQ-035 All outputs are derived from registered state and current inputs; there are no latches and no combinational loops through stall.

Verification (DEPTH=4)
REQ-036 Stall 3 cycles with inst_valid=1 throughout, then release -> write_en pulses 3 times, count reaches 3, state goes FILL then DRAIN; read_en is high 3 cycles (with new writes, count stays at 3 until inst_valid drops), then state returns to IDLE.
REQ-037 Stall 6 cycles with inst_valid=1 -> count saturates at 4; if_buffer_stall=1 from the cycle count=4 onward; write_en=0 at full; no count value of 5 is ever seen.
REQ-038 In DRAIN with count=2, assert redirect for 1 cycle -> next state is FLUSH with buffer_reset=1 and count=0, then IDLE one cycle later with buffer_sel=0.
REQ-039 In DRAIN with count=1, inst_valid=1 and stall=0 -> read_en=1 and write_en=1 together, count stays at 1, state remains DRAIN.
REQ-040 In DRAIN, reassert stall -> read_en=0 the same cycle, state goes to FILL, and count increments when inst_valid=1.
REQ-041 Assert reset during FILL with count=3 -> next cycle state=IDLE, count=0, all enables 0.
